// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-format codes
// for the RV immediate decode path.
package imm_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_R     = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_NONE  = 3'd7
    } imm_type_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate extraction, format classification
// and PC-relative target for one instruction word.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output imm_type_t       imm_type,
    output logic            illegal,
    output logic [XLEN-1:0] target
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       is_shift;
    logic       is_itype;
    logic       pcrel;

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [XLEN-1:0]    shamt;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];

    assign is_shift = (opc == OPC_OP_IMM)
                    && (f3 == 3'b001 || f3 == 3'b101);
    assign is_itype = (opc == OPC_OP_IMM && !is_shift)
                    || opc == OPC_LOAD || opc == OPC_JALR;

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    // RV64 shifts carry a 6-bit shamt, RV32 only 5
    assign shamt = (XLEN == 64) ? XLEN'(instr[25:20])
                                : XLEN'(instr[24:20]);

    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        unique case (1'b1)
            is_shift: begin
                imm      = shamt;
                imm_type = IMM_SHAMT;
            end
            is_itype: begin
                imm      = XLEN'(imm_i);
                imm_type = IMM_I;
            end
            (opc == OPC_STORE): begin
                imm      = XLEN'(imm_s);
                imm_type = IMM_S;
            end
            (opc == OPC_BRANCH): begin
                imm      = XLEN'(imm_b);
                imm_type = IMM_B;
            end
            (opc == OPC_LUI || opc == OPC_AUIPC): begin
                imm      = XLEN'(imm_u);
                imm_type = IMM_U;
            end
            (opc == OPC_JAL): begin
                imm      = XLEN'(imm_j);
                imm_type = IMM_J;
            end
            (opc == OPC_OP): begin
                imm_type = IMM_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign pcrel = opc == OPC_BRANCH || opc == OPC_JAL
                 || opc == OPC_AUIPC;

    // JALR target needs rs1, which this stage does not see
    assign target = pcrel ? pc + imm : '0;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with valid/ready handshake
// and optional 2-entry skid buffer holding decoded results.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_type_t       out_imm_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_t       imm_type;
        logic [XLEN-1:0] target;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } dec_t;

    dec_t            dec;
    dec_t            out_q;
    dec_t            skid_q;
    logic            out_v;
    logic            skid_v;
    logic            in_hs;
    logic [XLEN-1:0] d_imm;
    imm_type_t       d_type;
    logic            d_ill;
    logic [XLEN-1:0] d_tgt;

    imm_decode_comb #(.XLEN(XLEN)) u_comb (
        .instr    (in_instr),
        .pc       (in_pc),
        .imm      (d_imm),
        .imm_type (d_type),
        .illegal  (d_ill),
        .target   (d_tgt)
    );

    always_comb begin
        dec          = '0;
        dec.imm      = d_imm;
        dec.imm_type = d_type;
        dec.target   = d_tgt;
        dec.illegal  = d_ill;
        dec.pc       = in_pc;
    end

    assign in_ready = SKID ? !skid_v : (!out_v || out_ready);
    assign in_hs    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_v && !out_ready) begin
            // output stalled: a new arrival parks in the skid entry
            if (in_hs) begin
                skid_v <= 1'b1;
                skid_q <= dec;
            end
        end else if (skid_v) begin
            out_q  <= skid_q;
            skid_v <= 1'b0;
        end else begin
            out_v <= in_hs;
            if (in_hs) begin
                out_q <= dec;
            end
        end
    end

    assign out_valid    = out_v;
    assign out_imm      = out_q.imm;
    assign out_imm_type = out_q.imm_type;
    assign out_target   = out_q.target;
    assign out_illegal  = out_q.illegal;
    assign out_pc       = out_q.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode table at XLEN 32/64,
// skid backpressure ordering, flush and reset discards.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] pc32;
    logic [63:0] pc64;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32, out_tgt32, out_pc32;
    imm_type_t   out_type32;

    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64, out_tgt64, out_pc64;
    imm_type_t   out_type64;

    int checks;
    int failures;

    imm_decode_stage #(.XLEN(32), .SKID(1'b1)) dut32 (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready32),
        .in_instr     (in_instr),
        .in_pc        (pc32),
        .out_valid    (out_valid32),
        .out_ready    (out_ready),
        .out_imm      (out_imm32),
        .out_imm_type (out_type32),
        .out_target   (out_tgt32),
        .out_illegal  (out_ill32),
        .out_pc       (out_pc32)
    );

    imm_decode_stage #(.XLEN(64), .SKID(1'b1)) dut64 (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready64),
        .in_instr     (in_instr),
        .in_pc        (pc64),
        .out_valid    (out_valid64),
        .out_ready    (out_ready),
        .out_imm      (out_imm64),
        .out_imm_type (out_type64),
        .out_target   (out_tgt64),
        .out_illegal  (out_ill64),
        .out_pc       (out_pc64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm32;
        logic [63:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        imm_type_t   ty;
        logic        ill;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] addi_word(input int i);
        return {i[11:0], 20'h00013};
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        @(negedge clk);
        chk($sformatf("v%0d idle_valid", k), 64'(out_valid32), 64'd0);
        chk($sformatf("v%0d in_ready", k), 64'(in_ready32), 64'd1);
        in_valid  = 1'b1;
        in_instr  = v.instr;
        pc32      = v.pc[31:0];
        pc64      = v.pc;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d lat_valid32", k), 64'(out_valid32), 64'd1);
        chk($sformatf("v%0d imm32", k), 64'(out_imm32), v.imm32);
        chk($sformatf("v%0d tgt32", k), 64'(out_tgt32), v.tgt32);
        chk($sformatf("v%0d type32", k), 64'(out_type32), 64'(v.ty));
        chk($sformatf("v%0d ill32", k), 64'(out_ill32), 64'(v.ill));
        chk($sformatf("v%0d pc32", k), 64'(out_pc32), {32'd0, v.pc[31:0]});
        chk($sformatf("v%0d lat_valid64", k), 64'(out_valid64), 64'd1);
        chk($sformatf("v%0d imm64", k), out_imm64, v.imm64);
        chk($sformatf("v%0d tgt64", k), out_tgt64, v.tgt64);
        chk($sformatf("v%0d type64", k), 64'(out_type64), 64'(v.ty));
        chk($sformatf("v%0d ill64", k), 64'(out_ill64), 64'(v.ill));
        chk($sformatf("v%0d pc64", k), out_pc64, v.pc);
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, " valid"}, 64'(out_valid32), 64'd0);
        chk({nm, " in_ready"}, 64'(in_ready32), 64'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " imm"}, 64'(out_imm32), 64'd0);
        chk({nm, " tgt"}, 64'(out_tgt32), 64'd0);
        chk({nm, " pc"}, 64'(out_pc32), 64'd0);
        chk({nm, " ill"}, 64'(out_ill32), 64'd0);
        chk({nm, " type"}, 64'(out_type32), 64'(IMM_R));
        chk({nm, " imm64"}, out_imm64, 64'd0);
    endtask

    // loads W1 into output, W2 into skid, then pulses flush or rst
    // while W3 is offered
    task automatic full_discard(input bit use_rst);
        string nm;
        nm = use_rst ? "rst" : "flush";
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = addi_word(12'h7A1);
        pc32      = 32'h40;
        pc64      = 64'h40;
        @(negedge clk);
        in_instr = addi_word(12'h7A2);
        @(negedge clk);
        in_instr = addi_word(12'h7A3);
        chk({nm, " skid_full"}, 64'(in_ready32), 64'd0);
        chk({nm, " held_imm"}, 64'(out_imm32), 64'h7A1);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk_cleared({nm, "_next"});
        if (use_rst) chk_zero({nm, "_data"});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("%s no_leak%0d", nm, i), 64'(out_valid32), 64'd0);
        end
    endtask

    initial begin
        int sent;
        int recv;
        int occ;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        pc32      = '0;
        pc64      = '0;
        out_ready = 1'b0;

        vt[0]  = '{32'hFFF00093, 64'h0, 64'hFFFFFFFF, 64'h0,
                   64'hFFFFFFFFFFFFFFFF, 64'h0, IMM_I, 1'b0};
        vt[1]  = '{32'hFE000EE3, 64'h100, 64'hFFFFFFFC, 64'hFC,
                   64'hFFFFFFFFFFFFFFFC, 64'hFC, IMM_B, 1'b0};
        vt[2]  = '{32'hFE000FE3, 64'h100, 64'hFFFFFFFE, 64'hFE,
                   64'hFFFFFFFFFFFFFFFE, 64'hFE, IMM_B, 1'b0};
        vt[3]  = '{32'h0080006F, 64'h200, 64'h8, 64'h208,
                   64'h8, 64'h208, IMM_J, 1'b0};
        vt[4]  = '{32'h123452B7, 64'h0, 64'h12345000, 64'h0,
                   64'h12345000, 64'h0, IMM_U, 1'b0};
        vt[5]  = '{32'h800002B7, 64'h0, 64'h80000000, 64'h0,
                   64'hFFFFFFFF80000000, 64'h0, IMM_U, 1'b0};
        vt[6]  = '{32'h40515093, 64'h0, 64'h5, 64'h0,
                   64'h5, 64'h0, IMM_SHAMT, 1'b0};
        vt[7]  = '{32'h0000007F, 64'h300, 64'h0, 64'h0,
                   64'h0, 64'h0, IMM_NONE, 1'b1};
        vt[8]  = '{32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h4,
                   64'h8, 64'h4, IMM_J, 1'b0};
        vt[9]  = '{32'h00001297, 64'h1000, 64'h1000, 64'h2000,
                   64'h1000, 64'h2000, IMM_U, 1'b0};
        vt[10] = '{32'hFE112E23, 64'h0, 64'hFFFFFFFC, 64'h0,
                   64'hFFFFFFFFFFFFFFFC, 64'h0, IMM_S, 1'b0};
        vt[11] = '{32'h002081B3, 64'h0, 64'h0, 64'h0,
                   64'h0, 64'h0, IMM_R, 1'b0};
        vt[12] = '{32'h7FF02283, 64'h0, 64'h7FF, 64'h0,
                   64'h7FF, 64'h0, IMM_I, 1'b0};
        vt[13] = '{32'hFF808067, 64'h40, 64'hFFFFFFF8, 64'h0,
                   64'hFFFFFFFFFFFFFFF8, 64'h0, IMM_I, 1'b0};
        vt[14] = '{32'h02109093, 64'h0, 64'h1, 64'h0,
                   64'h21, 64'h0, IMM_SHAMT, 1'b0};
        vt[15] = '{32'hFFFFF297, 64'h10, 64'hFFFFF000, 64'hFFFFF010,
                   64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFFFF010,
                   IMM_U, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_cleared("reset");
        chk_zero("reset");
        chk("reset valid64", 64'(out_valid64), 64'd0);

        for (int k = 0; k < 16; k++) begin
            run_vec(k, vt[k]);
        end

        // backpressure: 10 words, output stalled in cycles 3..5
        @(negedge clk);
        in_valid = 1'b0;
        sent = 0;
        recv = 0;
        occ  = 0;
        for (int c = 0; c < 40 && recv < 10; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = sent < 10;
            in_instr  = addi_word(sent + 1);
            pc32      = 32'(sent * 4);
            chk($sformatf("skid c%0d in_ready", c),
                64'(in_ready32), 64'(occ < 2));
            chk($sformatf("skid c%0d out_valid", c),
                64'(out_valid32), 64'(occ > 0));
            if (out_valid32 && out_ready) begin
                chk($sformatf("skid order%0d", recv),
                    64'(out_imm32), 64'(recv + 1));
                recv++;
                occ--;
            end
            if (in_valid && in_ready32) begin
                sent++;
                occ++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("skid count", 64'(recv), 64'd10);

        // flush on an empty-input stage while the output is handed off
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = addi_word(12'h555);
        @(negedge clk);
        chk("fl_out loaded", 64'(out_valid32), 64'd1);
        in_instr  = addi_word(12'h556);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_cleared("fl_out_next");
        @(negedge clk);
        chk("fl_out no_leak", 64'(out_valid32), 64'd0);

        full_discard(1'b0);
        full_discard(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
